writeback_stage: RTL and testbench

- Consumer end of the memory-to-writeback pipeline register. Takes the W-stage bundle: RegWriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, PCPlus4W.
- Selects ResultW and commits it into the 32x32 architectural register file.
- Serves the decode stage's two read ports, with write-through bypass.
- Drives ResultW to the execute-stage forwarding muxes and exposes a0 (x10) for the F1 test harness.

---
 rtl/writeback_stage_pkg.sv | 23 ++
 rtl/writeback_stage_if.sv | 29 ++
 rtl/writeback_stage_reg_file.sv | 52 +++++
 rtl/writeback_stage.sv | 75 +++++++
 tb/tb_writeback_stage.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared constants and types for the writeback stage: result-select encodings,
// the a0 register index and the W-stage bundle struct.
package writeback_stage_pkg;

    localparam int WB_D_WIDTH = 32;
    localparam int WB_A_WIDTH = 5;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [WB_A_WIDTH-1:0] REG_A0 = 5'd10;

    typedef struct packed {
        logic                  reg_write;
        logic [1:0]            result_src;
        logic [WB_A_WIDTH-1:0] rd;
        logic [WB_D_WIDTH-1:0] alu_result;
        logic [WB_D_WIDTH-1:0] read_data;
        logic [WB_D_WIDTH-1:0] pc_plus4;
    } wb_bundle_t;

endpackage

// File: rtl/writeback_stage_if.sv
// W-stage bundle, decode read ports and forwarding/observation outputs.
// master = pipeline side (MEM/WB register + decode), slave = writeback stage.
interface writeback_stage_if #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5
);
    logic               RegWriteW;
    logic [1:0]         ResultSrcW;
    logic [A_WIDTH-1:0] RdW;
    logic [D_WIDTH-1:0] ALUResultW;
    logic [D_WIDTH-1:0] ReadDataW;
    logic [D_WIDTH-1:0] PCPlus4W;
    logic [A_WIDTH-1:0] A1;
    logic [A_WIDTH-1:0] A2;
    logic [D_WIDTH-1:0] RD1;
    logic [D_WIDTH-1:0] RD2;
    logic [D_WIDTH-1:0] ResultW;
    logic [D_WIDTH-1:0] a0;

    modport master (
        output RegWriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, PCPlus4W, A1, A2,
        input  RD1, RD2, ResultW, a0
    );

    modport slave (
        input  RegWriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, PCPlus4W, A1, A2,
        output RD1, RD2, ResultW, a0
    );
endinterface

// File: rtl/writeback_stage_reg_file.sv
// 2**A_WIDTH x D_WIDTH architectural register file: synchronous active-low reset,
// one write port, two write-through bypassed read ports and an a0 tap.
module writeback_stage_reg_file
    import writeback_stage_pkg::*;
#(
    parameter int D_WIDTH = WB_D_WIDTH,
    parameter int A_WIDTH = WB_A_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [A_WIDTH-1:0] wa,
    input  logic [D_WIDTH-1:0] wd,
    input  logic [A_WIDTH-1:0] a1,
    input  logic [A_WIDTH-1:0] a2,
    output logic [D_WIDTH-1:0] rd1,
    output logic [D_WIDTH-1:0] rd2,
    output logic [D_WIDTH-1:0] a0
);

    localparam int DEPTH = 2 ** A_WIDTH;

    logic [D_WIDTH-1:0] regs [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    // Bypass is intentionally not gated by rst_n; x0 short-circuits before any array access.
    always_comb begin
        rd1 = '0;
        if (a1 != '0) begin
            rd1 = (we && (wa == a1)) ? wd : regs[a1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (a2 != '0) begin
            rd2 = (we && (wa == a2)) ? wd : regs[a2];
        end
    end

    assign a0 = regs[REG_A0];

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: result mux, register-file commit and decode read ports.
// Optional retire counter output wb_count is enabled by defining WB_RETIRE_CNT_EN.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int D_WIDTH = WB_D_WIDTH,
    parameter int A_WIDTH = WB_A_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef WB_RETIRE_CNT_EN
    output logic [31:0]             wb_count,
`endif
    writeback_stage_if.slave        bus
);

    wb_bundle_t         w;
    logic [D_WIDTH-1:0] result;
    logic               commit;

    always_comb begin
        w.reg_write  = bus.RegWriteW;
        w.result_src = bus.ResultSrcW;
        w.rd         = bus.RdW;
        w.alu_result = bus.ALUResultW;
        w.read_data  = bus.ReadDataW;
        w.pc_plus4   = bus.PCPlus4W;
    end

    // Encoding 2'b11 is reserved and falls back to the ALU result.
    always_comb begin
        case (w.result_src)
            RES_MEM: result = w.read_data;
            RES_PC4: result = w.pc_plus4;
            default: result = w.alu_result;
        endcase
    end

    assign bus.ResultW = result;
    assign commit      = w.reg_write && (w.rd != '0);

    writeback_stage_reg_file #(
        .D_WIDTH (D_WIDTH),
        .A_WIDTH (A_WIDTH)
    ) u_reg_file (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w.reg_write),
        .wa    (w.rd),
        .wd    (result),
        .a1    (bus.A1),
        .a2    (bus.A2),
        .rd1   (bus.RD1),
        .rd2   (bus.RD2),
        .a0    (bus.a0)
    );

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] wb_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_count_q <= '0;
        end else if (commit) begin
            wb_count_q <= wb_count_q + 32'd1;
        end
    end

    assign wb_count = wb_count_q;
`else
    logic unused_commit;
    assign unused_commit = commit;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus a randomized
// scoreboard run against a reference register model.
module tb_writeback_stage;

    logic clk;
    logic rst_n;

    writeback_stage_if #(.D_WIDTH(32), .A_WIDTH(5)) bus ();

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] wb_count;
`endif

    writeback_stage dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef WB_RETIRE_CNT_EN
        .wb_count (wb_count),
`endif
        .bus      (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] mdl [32];
    logic [31:0] mdl_cnt;
    logic [31:0] exp_q [$];
    int          tests_run;
    int          tests_failed;

    function automatic logic [31:0] exp_result(input logic [1:0] src, input logic [31:0] alu,
                                               input logic [31:0] mem, input logic [31:0] pc4);
        case (src)
            2'b01:   return mem;
            2'b10:   return pc4;
            default: return alu;
        endcase
    endfunction

    function automatic logic [31:0] cur_result();
        return exp_result(bus.ResultSrcW, bus.ALUResultW, bus.ReadDataW, bus.PCPlus4W);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (bus.RegWriteW && (bus.RdW == a)) return cur_result();
        return mdl[a];
    endfunction

    // ---------------- drivers ----------------
    task automatic drive(input logic we, input logic [1:0] src, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4);
        bus.RegWriteW  = we;
        bus.ResultSrcW = src;
        bus.RdW        = rd;
        bus.ALUResultW = alu;
        bus.ReadDataW  = mem;
        bus.PCPlus4W   = pc4;
        #1;
    endtask

    task automatic set_reads(input logic [4:0] a1, input logic [4:0] a2);
        bus.A1 = a1;
        bus.A2 = a2;
        #1;
    endtask

    // One rising edge; the model applies the same edge, then outputs settle.
    task automatic step();
        logic        do_rst;
        logic        do_commit;
        logic [4:0]  rd;
        logic [31:0] res;
        do_rst    = !rst_n;
        do_commit = rst_n && bus.RegWriteW && (bus.RdW != 5'd0);
        rd        = bus.RdW;
        res       = cur_result();
        @(posedge clk);
        if (do_rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
            mdl_cnt = 32'd0;
        end else if (do_commit) begin
            mdl[rd] = res;
            mdl_cnt = mdl_cnt + 32'd1;
        end
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive(1'b1, 2'b00, 5'd5, 32'h1234, 32'd0, 32'd0);
        step();
        drive(1'b1, 2'b01, 5'd10, 32'd0, 32'h4321, 32'd0);
        step();
        idle();
        set_reads(5'd5, 5'd10);
        tests_run++;
        if (bus.RD1 !== 32'h1234) begin
            tests_failed++;
            $display("FAIL reset_preload: RD1=%h expected %h", bus.RD1, 32'h1234);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (bus.RD1 !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_x5: RD1=%h expected 0", bus.RD1);
        end
        tests_run++;
        if (bus.a0 !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_a0: a0=%h expected 0", bus.a0);
        end
        tests_run++;
        if (bus.RD2 !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_x10_read: RD2=%h expected 0", bus.RD2);
        end
`ifdef WB_RETIRE_CNT_EN
        tests_run++;
        if (wb_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_count: wb_count=%h expected 0", wb_count);
        end
`endif
    endtask

    task automatic test_mux();
        logic [31:0] exp;
        set_reads(5'd0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 5'd10, 32'hA, 32'hB, 32'hC);
            exp = (i == 1) ? 32'hB : (i == 2) ? 32'hC : 32'hA;
            exp_q.push_back(exp);
            tests_run++;
            if (bus.ResultW !== exp) begin
                tests_failed++;
                $display("FAIL mux_result_sel%0d: ResultW=%h expected %h", i, bus.ResultW, exp);
            end
            tests_run++;
            if (bus.a0 !== mdl[10]) begin
                tests_failed++;
                $display("FAIL mux_a0_before_edge%0d: a0=%h expected %h", i, bus.a0, mdl[10]);
            end
            step();
            exp = exp_q.pop_front();
            tests_run++;
            if (bus.a0 !== exp) begin
                tests_failed++;
                $display("FAIL mux_a0_sel%0d: a0=%h expected %h", i, bus.a0, exp);
            end
        end
        idle();
    endtask

    task automatic test_x0();
        logic [31:0] cnt_before;
        cnt_before = mdl_cnt;
        drive(1'b1, 2'b00, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'd0);
        set_reads(5'd0, 5'd0);
        tests_run++;
        if (bus.RD1 !== 32'd0) begin
            tests_failed++;
            $display("FAIL x0_before: RD1=%h expected 0", bus.RD1);
        end
        step();
        tests_run++;
        if (bus.RD1 !== 32'd0) begin
            tests_failed++;
            $display("FAIL x0_after: RD1=%h expected 0", bus.RD1);
        end
`ifdef WB_RETIRE_CNT_EN
        tests_run++;
        if (wb_count !== cnt_before) begin
            tests_failed++;
            $display("FAIL x0_count: wb_count=%h expected %h", wb_count, cnt_before);
        end
`endif
        idle();
    endtask

    task automatic test_bypass();
        drive(1'b1, 2'b00, 5'd7, 32'h55, 32'd0, 32'd0);
        set_reads(5'd7, 5'd7);
        tests_run++;
        if (bus.RD1 !== 32'h55 || bus.RD2 !== 32'h55) begin
            tests_failed++;
            $display("FAIL bypass_same_cycle: RD1=%h RD2=%h expected 55", bus.RD1, bus.RD2);
        end
        step();
        drive(1'b0, 2'b00, 5'd7, 32'h66, 32'd0, 32'd0);
        tests_run++;
        if (bus.RD1 !== 32'h55 || bus.RD2 !== 32'h55) begin
            tests_failed++;
            $display("FAIL bypass_array: RD1=%h RD2=%h expected 55", bus.RD1, bus.RD2);
        end
        idle();
    endtask

    task automatic test_write_disable();
        drive(1'b1, 2'b00, 5'd3, 32'h99, 32'd0, 32'd0);
        step();
        drive(1'b0, 2'b00, 5'd3, 32'h11, 32'd0, 32'd0);
        set_reads(5'd3, 5'd0);
        tests_run++;
        if (bus.RD1 !== 32'h99) begin
            tests_failed++;
            $display("FAIL wdis_before: RD1=%h expected 99", bus.RD1);
        end
        step();
        tests_run++;
        if (bus.RD1 !== 32'h99) begin
            tests_failed++;
            $display("FAIL wdis_after: RD1=%h expected 99", bus.RD1);
        end
        idle();
    endtask

    task automatic test_reset_collision();
        drive(1'b1, 2'b00, 5'd4, 32'h77, 32'd0, 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idle();
        set_reads(5'd4, 5'd0);
        tests_run++;
        if (bus.RD1 !== 32'd0) begin
            tests_failed++;
            $display("FAIL collision_x4: RD1=%h expected 0", bus.RD1);
        end
`ifdef WB_RETIRE_CNT_EN
        tests_run++;
        if (wb_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL collision_count: wb_count=%h expected 0", wb_count);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b00, 5'(i + 1), 32'(i), 32'd0, 32'd0);
            step();
        end
        idle();
        tests_run++;
        if (wb_count !== 32'd3) begin
            tests_failed++;
            $display("FAIL count_three: wb_count=%h expected 3", wb_count);
        end
        @(negedge clk);
        force dut.wb_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.wb_count_q;
        drive(1'b1, 2'b00, 5'd9, 32'h1, 32'd0, 32'd0);
        step();
        idle();
        tests_run++;
        if (wb_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL count_wrap: wb_count=%h expected 0", wb_count);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] ea0;
        for (int n = 0; n < 60; n++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                  $urandom, $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                set_reads(bus.RdW, bus.RdW);
            end else begin
                set_reads(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            end
            exp_q.push_back(exp_rd(bus.A1));
            exp_q.push_back(exp_rd(bus.A2));
            e1 = exp_q.pop_front();
            e2 = exp_q.pop_front();
            tests_run++;
            if (bus.RD1 !== e1 || bus.RD2 !== e2) begin
                tests_failed++;
                $display("FAIL rand_read%0d: A1=%0d RD1=%h exp %h A2=%0d RD2=%h exp %h",
                         n, bus.A1, bus.RD1, e1, bus.A2, bus.RD2, e2);
            end
            step();
            ea0 = mdl[10];
            tests_run++;
            if (bus.a0 !== ea0) begin
                tests_failed++;
                $display("FAIL rand_a0%0d: a0=%h expected %h", n, bus.a0, ea0);
            end
        end
        idle();
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        mdl_cnt      = 32'd0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        rst_n = 1'b0;
        idle();
        set_reads(5'd0, 5'd0);
        step();
        step();
        rst_n = 1'b1;

        test_reset();
        test_mux();
        test_x0();
        test_bypass();
        test_write_disable();
        test_random();
        test_reset_collision();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
